msk_sym_sched: RTL and testbench
================================

// Module: msk_sym_sched
// PURPOSE
//  Symbol-strobe scheduler for the MSK receive chain. Counts valid IQ samples and emits a
//  one-clock symbol strobe (feeds the demod sym_val_i) at a programmable sample phase.
//  Accepts early/late nudges from a timing-error detector, rate-limits them and tracks lock.
//  Runs at the sample clock; the downstream demod consumes one strobe per symbol.
// PARAMETERS
//  SPS        20  samples per symbol (FS/F_SYM); 4..(2**CNT_W)-2
//  CNT_W      8   sample-counter width
//  ADJ_HOLD   4   symbols to ignore further adjusts after an accepted one
//  LOCK_CNT   16  consecutive strobes without accepted adjust to declare lock
//  UNLOCK_ADJ 4   consecutive same-direction accepted adjusts that drop lock
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      synchronous reset, active-low
//  enable_i     in   1      run; low forces IDLE
//  iq_val_i     in   1      one IQ sample valid this cycle
//  phase_cfg_i  in   CNT_W  strobe sample index within symbol (sampled on IDLE->ACQ)
//  adj_early_i  in   1      pulse: strobe is late, shorten next symbol by 1 sample
//  adj_late_i   in   1      pulse: strobe is early, lengthen next symbol by 1 sample
//  sym_val_o    out  1      one-cycle symbol strobe
//  locked_o     out  1      high in TRACK
//  adj_drop_o   out  1      pulse: adjust request discarded (hold active or conflict)
//  sym_cnt_o    out  16     strobe count, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; cnt, target, pending, hold, lock/unlock counters 0.
//  States: IDLE -> ACQ when enable_i=1; ACQ -> TRACK after LOCK_CNT clean strobes;
//   TRACK -> ACQ after UNLOCK_ADJ consecutive same-direction accepted adjusts
//   (direction change restarts that count at 1); any state -> IDLE when enable_i=0
//   (next clk; counters/pending/hold cleared, sym_cnt_o held, no strobe that cycle).
//  IDLE->ACQ: cnt<=0, target<=phase_cfg_i, clamped to SPS-1 if >= SPS; len<=SPS.
//  Counter: advances only on iq_val_i; counts 0..len-1, then wraps to 0 (wrap event).
//  Strobe: sym_val_o=1 the clk after an iq_val_i cycle with cnt==target; latency 1 clk;
//   exactly one strobe per symbol period; sym_cnt_o increments with each strobe.
//  Adjust request: early XOR late, only while ACQ/TRACK.
//   Accepted if hold==0 and no pending: sets pending dir; hold<=ADJ_HOLD.
//   Both high same cycle, or hold!=0, or pending set -> discarded, adj_drop_o=1 one clk.
//   Requests in IDLE ignored silently.
//  Apply: at wrap event, len<=SPS-1 (early) / SPS+1 (late) / SPS (none); pending cleared.
//   Target unchanged; if len=SPS-1 and target=SPS-1, strobe that period at cnt=SPS-2.
//  hold decrements on each strobe, saturates at 0.
//  Lock counter: +1 per strobe, cleared on accepted adjust; saturates at LOCK_CNT.
//  locked_o registered: =1 the clk after entering TRACK, 0 the clk after leaving.
//  Strobe and accepted adjust in same cycle: both take effect; adjust restarts lock count.
//  Reset mid-symbol: next clk all state as reset, no partial strobe.
// TESTING
//  1 enable, iq_val every clk, phase_cfg=10 -> first strobe clk 12 after enable, then
//    every 20 clks; sym_cnt_o counts 1,2,3.
//  2 iq_val 1-in-4 duty, phase_cfg=25 -> target clamped 19; strobe every 80 clks.
//  3 adj_early at cycle 5 of a symbol -> next period 19 samples; second adj 1 symbol
//    later -> adj_drop_o pulse, period stays 20.
//  4 no adjusts 16 strobes -> locked_o=1 clk after 16th; then 4 accepted early
//    adjusts 5 symbols apart -> locked_o=0 after 4th; early,late alternating keeps lock.
//  5 adj_early and adj_late same clk -> adj_drop_o=1, no period change, hold stays 0.
//  6 enable_i low mid-symbol then high -> no strobe, restart at cnt 0; reset_n low
//    mid-symbol -> all outputs 0 next clk, sym_cnt_o=0.

Source files
------------

// File: rtl/msk_sym_sched.sv
// rtl/msk_sym_sched.sv - MSK symbol-strobe scheduler with rate-limited timing nudges and lock tracking.
module msk_sym_sched #(
   parameter int SPS        = 20,
   parameter int CNT_W      = 8,
   parameter int ADJ_HOLD   = 4,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_ADJ = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable_i,
   input  logic             iq_val_i,
   input  logic [CNT_W-1:0] phase_cfg_i,
   input  logic             adj_early_i,
   input  logic             adj_late_i,
   output logic             sym_val_o,
   output logic             locked_o,
   output logic             adj_drop_o,
   output logic [15:0]      sym_cnt_o
);
   localparam int HW = $clog2(ADJ_HOLD + 1);
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int UW = $clog2(UNLOCK_ADJ + 1);

   localparam logic [CNT_W-1:0] SPS_C  = CNT_W'(SPS);
   localparam logic [CNT_W-1:0] SPS_M1 = CNT_W'(SPS - 1);
   localparam logic [CNT_W-1:0] SPS_P1 = CNT_W'(SPS + 1);
   localparam logic [HW-1:0]    HOLD_C = HW'(ADJ_HOLD);
   localparam logic [LW-1:0]    LOCK_C = LW'(LOCK_CNT);
   localparam logic [UW-1:0]    UNLK_C = UW'(UNLOCK_ADJ);

   typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, target_q, target_d, len_q, len_d;
   logic             pend_q, pend_d, pend_late_q, pend_late_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [LW-1:0]    lock_q, lock_d;
   logic [UW-1:0]    unlk_q, unlk_d;
   logic             unlk_late_q, unlk_late_d;
   logic             sym_val_q, sym_val_d, locked_q, locked_d, adj_drop_q, adj_drop_d;
   logic [15:0]      sym_cnt_q, sym_cnt_d;

   logic             active, strobe, wrap, req_any, accept;
   logic [CNT_W-1:0] eff_target;

   // A shortened symbol may be too short to reach the target; strobe on its last sample instead.
   assign eff_target = (target_q >= len_q) ? len_q - 1'b1 : target_q;
   assign active     = (state_q != IDLE) && enable_i;
   assign strobe     = active && iq_val_i && (cnt_q == eff_target);
   assign wrap       = active && iq_val_i && (cnt_q == len_q - 1'b1);
   assign req_any    = active && (adj_early_i || adj_late_i);
   assign accept     = req_any && (adj_early_i ^ adj_late_i) && (hold_q == '0) && !pend_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      target_d    = target_q;
      len_d       = len_q;
      pend_d      = pend_q;
      pend_late_d = pend_late_q;
      hold_d      = hold_q;
      lock_d      = lock_q;
      unlk_d      = unlk_q;
      unlk_late_d = unlk_late_q;
      sym_cnt_d   = sym_cnt_q;
      sym_val_d   = 1'b0;
      adj_drop_d  = 1'b0;
      locked_d    = (state_q == TRACK);

      if (!enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         pend_d  = 1'b0;
         hold_d  = '0;
         lock_d  = '0;
         unlk_d  = '0;
      end else if (state_q == IDLE) begin
         state_d  = ACQ;
         cnt_d    = '0;
         target_d = (phase_cfg_i >= SPS_C) ? SPS_M1 : phase_cfg_i;
         len_d    = SPS_C;
      end else begin
         if (iq_val_i)
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
         if (wrap) begin
            len_d  = !pend_q ? SPS_C : (pend_late_q ? SPS_P1 : SPS_M1);
            pend_d = 1'b0;
         end
         if (strobe) begin
            sym_val_d = 1'b1;
            sym_cnt_d = sym_cnt_q + 16'd1;
            hold_d    = (hold_q == '0) ? '0 : hold_q - 1'b1;
            lock_d    = (lock_q == LOCK_C) ? lock_q : lock_q + 1'b1;
         end
         if (accept) begin
            pend_d      = 1'b1;
            pend_late_d = adj_late_i;
            hold_d      = HOLD_C;
            lock_d      = '0;
         end
         adj_drop_d = req_any && !accept;

         if (state_q == ACQ) begin
            unlk_d = '0;
            if (lock_d == LOCK_C)
               state_d = TRACK;
         end else if (accept) begin
            // Only a run of same-direction corrections indicates lost timing.
            unlk_d      = (unlk_q != '0 && unlk_late_q == adj_late_i) ? unlk_q + 1'b1 : UW'(1);
            unlk_late_d = adj_late_i;
            if (unlk_d == UNLK_C) begin
               state_d = ACQ;
               unlk_d  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         target_q    <= '0;
         len_q       <= '0;
         pend_q      <= 1'b0;
         pend_late_q <= 1'b0;
         hold_q      <= '0;
         lock_q      <= '0;
         unlk_q      <= '0;
         unlk_late_q <= 1'b0;
         sym_val_q   <= 1'b0;
         locked_q    <= 1'b0;
         adj_drop_q  <= 1'b0;
         sym_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         target_q    <= target_d;
         len_q       <= len_d;
         pend_q      <= pend_d;
         pend_late_q <= pend_late_d;
         hold_q      <= hold_d;
         lock_q      <= lock_d;
         unlk_q      <= unlk_d;
         unlk_late_q <= unlk_late_d;
         sym_val_q   <= sym_val_d;
         locked_q    <= locked_d;
         adj_drop_q  <= adj_drop_d;
         sym_cnt_q   <= sym_cnt_d;
      end
   end

   assign sym_val_o  = sym_val_q;
   assign locked_o   = locked_q;
   assign adj_drop_o = adj_drop_q;
   assign sym_cnt_o  = sym_cnt_q;
endmodule

// File: tb/tb_msk_sym_sched.sv
// tb/tb_msk_sym_sched.sv - directed table and sequence checks for msk_sym_sched.
module tb_msk_sym_sched;
   logic        clk = 1'b0;
   logic        reset_n, enable_i, iq_val_i, adj_early_i, adj_late_i;
   logic [7:0]  phase_cfg_i;
   logic        sym_val_o, locked_o, adj_drop_o;
   logic [15:0] sym_cnt_o;

   msk_sym_sched dut (
      .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .iq_val_i(iq_val_i),
      .phase_cfg_i(phase_cfg_i), .adj_early_i(adj_early_i), .adj_late_i(adj_late_i),
      .sym_val_o(sym_val_o), .locked_o(locked_o), .adj_drop_o(adj_drop_o),
      .sym_cnt_o(sym_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int phase;
      int div;
      int first;
      int period;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int strobes[$];
   int drops[$];
   int adj_e[$];
   int adj_l[$];
   int lock_rise, lock_fall;
   vec_t tbl[5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int st(input int i);
      return (i < strobes.size()) ? strobes[i] : -1;
   endfunction

   function automatic int dr(input int i);
      return (i < drops.size()) ? drops[i] : -1;
   endfunction

   task automatic do_reset();
      reset_n = 1'b0; enable_i = 1'b0; iq_val_i = 1'b0;
      adj_early_i = 1'b0; adj_late_i = 1'b0; phase_cfg_i = 8'd0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Edge k=1 is the first edge that sees enable_i high.
   task automatic run(input int n, input int div);
      logic prev_lock;
      strobes.delete(); drops.delete();
      lock_rise = -1; lock_fall = -1;
      for (int k = 1; k <= n; k++) begin
         adj_early_i = 1'b0;
         adj_late_i  = 1'b0;
         foreach (adj_e[i]) if (adj_e[i] == k) adj_early_i = 1'b1;
         foreach (adj_l[i]) if (adj_l[i] == k) adj_late_i = 1'b1;
         iq_val_i  = ((k - 1) % div == 0);
         prev_lock = locked_o;
         @(posedge clk); #1;
         if (sym_val_o)  strobes.push_back(k);
         if (adj_drop_o) drops.push_back(k);
         if (locked_o && !prev_lock) lock_rise = k;
         if (!locked_o && prev_lock) lock_fall = k;
      end
      iq_val_i = 1'b0; adj_early_i = 1'b0; adj_late_i = 1'b0;
   endtask

   initial begin
      tbl[0] = '{10, 1, 12, 20};
      tbl[1] = '{25, 4, 81, 80};
      tbl[2] = '{0,  1, 2,  20};
      tbl[3] = '{19, 2, 41, 40};
      tbl[4] = '{255, 1, 21, 20};

      do_reset();
      chk("rst_sym_val", int'(sym_val_o), 0);
      chk("rst_locked", int'(locked_o), 0);
      chk("rst_adj_drop", int'(adj_drop_o), 0);
      chk("rst_sym_cnt", int'(sym_cnt_o), 0);

      foreach (tbl[v]) begin
         do_reset();
         adj_e.delete(); adj_l.delete();
         phase_cfg_i = 8'(tbl[v].phase);
         enable_i = 1'b1;
         run(tbl[v].first + 2 * tbl[v].period + 2, tbl[v].div);
         chk($sformatf("tbl%0d_count", v), strobes.size(), 3);
         chk($sformatf("tbl%0d_first", v), st(0), tbl[v].first);
         chk($sformatf("tbl%0d_per1", v), st(1) - st(0), tbl[v].period);
         chk($sformatf("tbl%0d_per2", v), st(2) - st(1), tbl[v].period);
         chk($sformatf("tbl%0d_symcnt", v), int'(sym_cnt_o), 3);
      end

      // Early nudge shortens one symbol; a second nudge inside the hold window is dropped.
      do_reset();
      phase_cfg_i = 8'd10; enable_i = 1'b1;
      adj_e = '{27, 47}; adj_l.delete();
      run(95, 1);
      chk("adj_strobe3", st(2), 52);
      chk("adj_strobe4", st(3), 71);
      chk("adj_strobe5", st(4), 91);
      chk("adj_drop_cnt", drops.size(), 1);
      chk("adj_drop_at", dr(0), 47);

      // Conflicting nudge is dropped and leaves hold clear, so the next one is accepted.
      do_reset();
      phase_cfg_i = 8'd10; enable_i = 1'b1;
      adj_e = '{27, 47}; adj_l = '{27};
      run(95, 1);
      chk("conf_drop_cnt", drops.size(), 1);
      chk("conf_drop_at", dr(0), 27);
      chk("conf_strobe4", st(3), 72);
      chk("conf_strobe5", st(4), 91);

      // Lock after 16 clean strobes, lose it after 4 same-direction accepted nudges.
      do_reset();
      phase_cfg_i = 8'd10; enable_i = 1'b1;
      adj_e = '{333, 432, 531, 630}; adj_l.delete();
      run(640, 1);
      chk("lock_strobe16", st(15), 312);
      chk("lock_rise", lock_rise, 313);
      chk("lock_fall", lock_fall, 631);
      chk("lock_drops", drops.size(), 0);

      // Alternating directions keep lock.
      do_reset();
      phase_cfg_i = 8'd10; enable_i = 1'b1;
      adj_e = '{333, 531}; adj_l = '{432, 632};
      run(700, 1);
      chk("alt_rise", lock_rise, 313);
      chk("alt_fall", lock_fall, -1);
      chk("alt_locked", int'(locked_o), 1);
      chk("alt_drops", drops.size(), 0);

      // Reset mid-symbol while locked.
      reset_n = 1'b0; iq_val_i = 1'b1;
      @(posedge clk); #1;
      chk("mrst_sym_val", int'(sym_val_o), 0);
      chk("mrst_locked", int'(locked_o), 0);
      chk("mrst_adj_drop", int'(adj_drop_o), 0);
      chk("mrst_sym_cnt", int'(sym_cnt_o), 0);
      reset_n = 1'b1;

      // Disable exactly on the strobe sample, then restart from sample 0.
      do_reset();
      phase_cfg_i = 8'd10; enable_i = 1'b1;
      adj_e.delete(); adj_l.delete();
      run(11, 1);
      enable_i = 1'b0; iq_val_i = 1'b1;
      @(posedge clk); #1;
      chk("dis_no_strobe", int'(sym_val_o), 0);
      chk("dis_symcnt", int'(sym_cnt_o), 0);
      enable_i = 1'b1;
      run(12, 1);
      chk("dis_restart_cnt", strobes.size(), 1);
      chk("dis_restart_at", st(0), 12);
      chk("dis_restart_symcnt", int'(sym_cnt_o), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
